// File: rtl/br_perf_monitor.sv
// rtl/br_perf_monitor.sv - branch prediction performance monitor with run/freeze FSM and windowed miss counts
// Optional macro BR_PERF_STREAK_EN adds max_streak_o (longest run of consecutive mispredicts per channel).
module br_perf_monitor #(
    parameter int CNT_W    = 32,
    parameter int NUM_CH   = 1,
    parameter int WIN_LOG2 = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic                           clr_i,
    input  logic                           br_instr_i,
    input  logic [NUM_CH-1:0]              br_miss_i,
    output logic [CNT_W-1:0]               cyc_cnt_o,
    output logic [CNT_W-1:0]               br_cnt_o,
    output logic [NUM_CH*CNT_W-1:0]        miss_cnt_o,
    output logic [NUM_CH*(WIN_LOG2+1)-1:0] win_miss_o,
    output logic                           win_done_o,
    output logic [1:0]                     state_o,
    output logic                           sat_o
`ifdef BR_PERF_STREAK_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]        max_streak_o
`endif
);

    localparam int WW = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;
    localparam logic [WIN_LOG2-1:0] WIN_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]               br_cnt_q, br_cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [NUM_CH-1:0][WW-1:0]      win_miss_q, win_miss_d;
    logic [NUM_CH-1:0][WW-1:0]      win_acc_q, win_acc_d;
    logic [WIN_LOG2-1:0]            win_br_q, win_br_d;
    logic                           win_done_q, win_done_d;
    logic                           sat_q, sat_d;
    logic                           hit;
`ifdef BR_PERF_STREAK_EN
    logic [NUM_CH-1:0][CNT_W-1:0]   cur_streak_q, cur_streak_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   max_streak_q, max_streak_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        win_miss_d = win_miss_q;
        win_acc_d  = win_acc_q;
        win_br_d   = win_br_q;
        win_done_d = 1'b0;
        hit        = 1'b0;
`ifdef BR_PERF_STREAK_EN
        cur_streak_d = cur_streak_q;
        max_streak_d = max_streak_q;
`endif

        if (state_q == ST_RUN) begin
            cyc_cnt_d = sat_inc(cyc_cnt_q);
            if (br_instr_i) begin
                br_cnt_d = sat_inc(br_cnt_q);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (br_miss_i[k]) begin
                        miss_cnt_d[k] = sat_inc(miss_cnt_q[k]);
                    end
`ifdef BR_PERF_STREAK_EN
                    if (br_miss_i[k]) begin
                        cur_streak_d[k] = sat_inc(cur_streak_q[k]);
                        if (cur_streak_d[k] > max_streak_q[k]) begin
                            max_streak_d[k] = cur_streak_d[k];
                        end
                    end else begin
                        cur_streak_d[k] = '0;
                    end
`endif
                end
                // The completing branch's own miss is folded into the published count.
                if (win_br_q == WIN_MAX) begin
                    win_br_d   = '0;
                    win_done_d = 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        win_miss_d[k] = win_acc_q[k] + WW'(br_miss_i[k]);
                        win_acc_d[k]  = '0;
                    end
                end else begin
                    win_br_d = win_br_q + WIN_LOG2'(1);
                    for (int k = 0; k < NUM_CH; k++) begin
                        win_acc_d[k] = win_acc_q[k] + WW'(br_miss_i[k]);
                    end
                end
            end

            hit = (cyc_cnt_d == CNT_MAX) || (br_cnt_d == CNT_MAX);
            for (int k = 0; k < NUM_CH; k++) begin
                if (miss_cnt_d[k] == CNT_MAX) begin
                    hit = 1'b1;
                end
`ifdef BR_PERF_STREAK_EN
                if (max_streak_d[k] == CNT_MAX) begin
                    hit = 1'b1;
                end
`endif
            end

            if (hit) begin
                state_d = ST_FROZEN;
            end else if (!en_i) begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_IDLE && en_i) begin
            state_d = ST_RUN;
        end

        sat_d = sat_q | hit;

        // Clear wins over everything, including a branch in the same cycle.
        if (clr_i) begin
            state_d    = ST_IDLE;
            cyc_cnt_d  = '0;
            br_cnt_d   = '0;
            miss_cnt_d = '0;
            win_miss_d = '0;
            win_acc_d  = '0;
            win_br_d   = '0;
            win_done_d = 1'b0;
            sat_d      = 1'b0;
`ifdef BR_PERF_STREAK_EN
            cur_streak_d = '0;
            max_streak_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cyc_cnt_q  <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
            win_miss_q <= '0;
            win_acc_q  <= '0;
            win_br_q   <= '0;
            win_done_q <= 1'b0;
            sat_q      <= 1'b0;
`ifdef BR_PERF_STREAK_EN
            cur_streak_q <= '0;
            max_streak_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            win_miss_q <= win_miss_d;
            win_acc_q  <= win_acc_d;
            win_br_q   <= win_br_d;
            win_done_q <= win_done_d;
            sat_q      <= sat_d;
`ifdef BR_PERF_STREAK_EN
            cur_streak_q <= cur_streak_d;
            max_streak_q <= max_streak_d;
`endif
        end
    end

    assign state_o    = state_q;
    assign cyc_cnt_o  = cyc_cnt_q;
    assign br_cnt_o   = br_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign win_miss_o = win_miss_q;
    assign win_done_o = win_done_q;
    assign sat_o      = sat_q;
`ifdef BR_PERF_STREAK_EN
    assign max_streak_o = max_streak_q;
`endif

endmodule

// File: tb/tb_br_perf_monitor.sv
// tb/tb_br_perf_monitor.sv - directed self-checking bench for br_perf_monitor
module tb_br_perf_monitor;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;

    logic        en, clr, br;
    logic [1:0]  miss;
    logic [7:0]  cyc_o, br_o;
    logic [15:0] miss_o;
    logic [5:0]  win_o;
    logic        done_o, sat_o;
    logic [1:0]  state_o;

    logic        en_s, clr_s, br_s;
    logic [0:0]  miss_s;
    logic [3:0]  cyc_s, br_cnt_s, miss_cnt_s;
    logic [2:0]  win_s;
    logic        done_s, sat_s;
    logic [1:0]  state_s;

    logic [7:0]  pat_br;
    logic [7:0]  pat_ms;

`ifdef BR_PERF_STREAK_EN
    logic [15:0] streak_o;
    logic [3:0]  streak_s;
`endif

    br_perf_monitor #(.CNT_W(8), .NUM_CH(2), .WIN_LOG2(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .br_instr_i(br), .br_miss_i(miss),
        .cyc_cnt_o(cyc_o), .br_cnt_o(br_o), .miss_cnt_o(miss_o), .win_miss_o(win_o),
        .win_done_o(done_o), .state_o(state_o), .sat_o(sat_o)
`ifdef BR_PERF_STREAK_EN
        , .max_streak_o(streak_o)
`endif
    );

    br_perf_monitor #(.CNT_W(4), .NUM_CH(1), .WIN_LOG2(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_s), .clr_i(clr_s), .br_instr_i(br_s), .br_miss_i(miss_s),
        .cyc_cnt_o(cyc_s), .br_cnt_o(br_cnt_s), .miss_cnt_o(miss_cnt_s), .win_miss_o(win_s),
        .win_done_o(done_s), .state_o(state_s), .sat_o(sat_s)
`ifdef BR_PERF_STREAK_EN
        , .max_streak_o(streak_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; br = 1'b0; miss = 2'b00;
        en_s = 1'b0; clr_s = 1'b0; br_s = 1'b0; miss_s = 1'b0;
        pat_br = 8'b1110_1111;
        pat_ms = 8'b0110_1011;
        tick(2);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cyc", 32'(cyc_o), 32'd0);
        chk("rst_miss", 32'(miss_o), 32'd0);
        chk("rst_win", 32'(win_o), 32'd0);
        chk("rst_done_sat", 32'({done_o, sat_o}), 32'd0);
        rst_n = 1'b1;

        // Ten cycles with en high, no branches
        en = 1'b1;
        tick(1);
        chk("run_entry_state", 32'(state_o), 32'd1);
        chk("run_entry_cyc", 32'(cyc_o), 32'd0);
        tick(9);
        en = 1'b0;
        tick(1);
        chk("idle_cyc", 32'(cyc_o), 32'd10);
        chk("idle_br", 32'(br_o), 32'd0);
        chk("idle_miss", 32'(miss_o), 32'd0);
        chk("idle_state", 32'(state_o), 32'd0);

        // Window of miss patterns 01,11,00,01
        en = 1'b1;
        tick(1);
        br = 1'b1;
        miss = 2'b01; tick(1);
        miss = 2'b11; tick(1);
        miss = 2'b00; tick(1);
        chk("win_not_done_yet", 32'(done_o), 32'd0);
        miss = 2'b01; tick(1);
        chk("win1_done", 32'(done_o), 32'd1);
        chk("win1_miss", 32'(win_o), 32'h0B);
        chk("win1_total", 32'(miss_o), 32'h0103);
        chk("win1_br", 32'(br_o), 32'd4);
        br = 1'b0; miss = 2'b00;
        tick(1);
        chk("win1_done_pulse", 32'(done_o), 32'd0);
        chk("win1_cyc", 32'(cyc_o), 32'd15);

        // All-miss window, then misses without a branch
        br = 1'b1; miss = 2'b11;
        tick(4);
        chk("win2_done", 32'(done_o), 32'd1);
        chk("win2_allmiss", 32'(win_o), 32'h24);
        chk("win2_total", 32'(miss_o), 32'h0507);
        br = 1'b0;
        tick(2);
        chk("nobr_miss", 32'(miss_o), 32'h0507);
        chk("nobr_br", 32'(br_o), 32'd8);
        chk("nobr_cyc", 32'(cyc_o), 32'd21);

        // Window split by an IDLE gap
        br = 1'b1; miss = 2'b01;
        tick(2);
        br = 1'b0; miss = 2'b00; en = 1'b0;
        tick(5);
        chk("gap_cyc", 32'(cyc_o), 32'd24);
        chk("gap_state", 32'(state_o), 32'd0);
        chk("gap_no_done", 32'(done_o), 32'd0);
        en = 1'b1;
        tick(1);
        br = 1'b1;
        tick(1);
        chk("gap_3rd_no_done", 32'(done_o), 32'd0);
        tick(1);
        chk("gap_done", 32'(done_o), 32'd1);
        chk("gap_win", 32'(win_o), 32'h02);
        chk("gap_cyc_after", 32'(cyc_o), 32'd26);
        chk("gap_br", 32'(br_o), 32'd12);

        // Clear with a coincident branch
        miss = 2'b11; clr = 1'b1;
        tick(1);
        chk("clr_cyc", 32'(cyc_o), 32'd0);
        chk("clr_br", 32'(br_o), 32'd0);
        chk("clr_miss", 32'(miss_o), 32'd0);
        chk("clr_win", 32'(win_o), 32'd0);
        chk("clr_state", 32'(state_o), 32'd0);
        clr = 1'b0; br = 1'b0; miss = 2'b00;
        tick(1);
        chk("clr_rerun_state", 32'(state_o), 32'd1);
        br = 1'b1; miss = 2'b01;
        tick(1);
        chk("clr_rerun_br", 32'(br_o), 32'd1);
        chk("clr_rerun_miss", 32'(miss_o), 32'h0001);

        // Streak pattern 1,1,0,1,(no branch),1,1,0 on ch0
        clr = 1'b1; br = 1'b0; miss = 2'b00;
        tick(1);
        clr = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            br = pat_br[i];
            miss = {1'b0, pat_ms[i]};
            tick(1);
        end
        br = 1'b0; miss = 2'b00;
        tick(1);
        chk("streak_miss", 32'(miss_o), 32'h0005);
        chk("streak_br", 32'(br_o), 32'd7);
`ifdef BR_PERF_STREAK_EN
        chk("streak_max", 32'(streak_o), 32'h0003);
`endif

        // Saturation on the 4-bit instance
        en_s = 1'b1;
        tick(20);
        chk("sat_cyc", 32'(cyc_s), 32'd15);
        chk("sat_flag", 32'(sat_s), 32'd1);
        chk("sat_state", 32'(state_s), 32'd2);
        en_s = 1'b0;
        tick(2);
        chk("sat_hold_state", 32'(state_s), 32'd2);
        chk("sat_hold_cyc", 32'(cyc_s), 32'd15);
        clr_s = 1'b1;
        tick(1);
        chk("sat_clr_cyc", 32'(cyc_s), 32'd0);
        chk("sat_clr_state_flag", 32'({state_s, sat_s}), 32'd0);
        clr_s = 1'b0;

        // Asynchronous reset in the middle of a window
        br = 1'b1; miss = 2'b11;
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_cyc_br", 32'({cyc_o, br_o}), 32'd0);
        chk("arst_miss", 32'(miss_o), 32'd0);
        chk("arst_win_done", 32'({win_o, done_o, sat_o}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
